// File: rtl/stream_extremum.sv
// Pipelined N-input max/min reduction with a per-beat threshold and a per-frame
// running extremum that is reported once at the end of each frame.
module stream_extremum #(
    parameter int unsigned      WIDTH = 8,
    parameter int unsigned      N     = 4,
    parameter logic [WIDTH-1:0] HI    = '1,
    parameter logic [WIDTH-1:0] LO    = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic               mode,
    input  logic               sof,
    input  logic               eof,
    input  logic [N*WIDTH-1:0] d,
    input  logic [WIDTH-1:0]   thresh,
    output logic [WIDTH-1:0]   q,
    output logic [WIDTH-1:0]   q_bin,
    output logic               q_valid,
    output logic [WIDTH-1:0]   frame_ext,
    output logic               frame_valid
);

    localparam int unsigned LAT   = $clog2(N);
    localparam int unsigned NODES = 2 * N - 2;

    // mn = 1 selects the minimum; ties return the shared value either way
    function automatic logic [WIDTH-1:0] f_ext(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic mn);
        if (mn) return (b < a) ? b : a;
        return (b > a) ? b : a;
    endfunction

    // first node index of tree level k inside the flat node array
    function automatic int unsigned f_base(input int unsigned k);
        return 2 * N - 2 * (N >> k);
    endfunction

    logic [LAT-1:0]   r_vld;
    logic [LAT-1:0]   r_mode;
    logic [LAT-1:0]   r_sof;
    logic [LAT-1:0]   r_eof;
    logic [WIDTH-1:0] r_node [NODES];

    generate
        for (genvar k = 0; k < LAT; k++) begin : g_lvl
            if (k == 0) begin : g_in
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_vld[0] <= 1'b0;
                        r_sof[0] <= 1'b0;
                        r_eof[0] <= 1'b0;
                    end else begin
                        r_vld[0] <= in_valid;
                        r_sof[0] <= in_valid & sof;
                        r_eof[0] <= in_valid & eof;
                        if (in_valid) r_mode[0] <= mode;
                    end
                end
                for (genvar j = 0; j < N; j++) begin : g_smp
                    always_ff @(posedge clk) begin
                        if (in_valid) r_node[j] <= d[j*WIDTH +: WIDTH];
                    end
                end
            end else begin : g_tree
                localparam int unsigned BASE  = f_base(k);
                localparam int unsigned PBASE = f_base(k - 1);
                always_ff @(posedge clk) begin
                    if (reset) begin
                        r_vld[k] <= 1'b0;
                        r_sof[k] <= 1'b0;
                        r_eof[k] <= 1'b0;
                    end else begin
                        r_vld[k] <= r_vld[k-1];
                        r_sof[k] <= r_sof[k-1];
                        r_eof[k] <= r_eof[k-1];
                        if (r_vld[k-1]) r_mode[k] <= r_mode[k-1];
                    end
                end
                for (genvar j = 0; j < (N >> k); j++) begin : g_node
                    always_ff @(posedge clk) begin
                        if (r_vld[k-1]) begin
                            r_node[BASE+j] <= f_ext(r_node[PBASE+2*j],
                                                    r_node[PBASE+2*j+1],
                                                    r_mode[k-1]);
                        end
                    end
                end
            end
        end
    endgenerate

    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_qbin;
    logic             r_qvld;
    logic             r_qmode;
    logic             r_qsof;
    logic             r_qeof;

    assign w_res = f_ext(r_node[NODES-2], r_node[NODES-1], r_mode[LAT-1]);

    // final tree level: result, threshold and frame tags registered together
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q     <= '0;
            r_qbin  <= '0;
            r_qvld  <= 1'b0;
            r_qmode <= 1'b0;
            r_qsof  <= 1'b0;
            r_qeof  <= 1'b0;
        end else begin
            r_qvld <= r_vld[LAT-1];
            r_qsof <= r_sof[LAT-1];
            r_qeof <= r_eof[LAT-1];
            if (r_vld[LAT-1]) begin
                r_q     <= w_res;
                r_qbin  <= (w_res > thresh) ? HI : LO;
                r_qmode <= r_mode[LAT-1];
            end
        end
    end

    logic [WIDTH-1:0] r_acc;
    logic             r_fmode;
    logic             r_in_frame;
    logic [WIDTH-1:0] r_fext;
    logic             r_fvld;
    logic [WIDTH-1:0] w_acc;

    assign w_acc = f_ext(r_acc, r_q, r_fmode);

    // frame accumulator; the sof beat fixes the frame's max/min sense
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_fmode    <= 1'b0;
            r_in_frame <= 1'b0;
            r_fext     <= '0;
            r_fvld     <= 1'b0;
        end else begin
            r_fvld <= 1'b0;
            if (r_qvld) begin
                if (r_qsof) begin
                    r_acc      <= r_q;
                    r_fmode    <= r_qmode;
                    r_in_frame <= ~r_qeof;
                    if (r_qeof) begin
                        r_fext <= r_q;
                        r_fvld <= 1'b1;
                    end
                end else if (r_in_frame) begin
                    r_acc <= w_acc;
                    if (r_qeof) begin
                        r_fext     <= w_acc;
                        r_fvld     <= 1'b1;
                        r_in_frame <= 1'b0;
                    end
                end
            end
        end
    end

    assign q           = r_q;
    assign q_bin       = r_qbin;
    assign q_valid     = r_qvld;
    assign frame_ext   = r_fext;
    assign frame_valid = r_fvld;

endmodule

// File: tb/tb_stream_extremum.sv
// Self-checking bench for stream_extremum (WIDTH=8, N=4): vector table, directed
// frame sequences and random traffic checked against a per-edge expectation model.
module tb_stream_extremum;

    localparam int unsigned LAT = 2;
    localparam int unsigned HN  = 4096;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        in_valid = 1'b1;
    logic        mode     = 1'b0;
    logic        sof      = 1'b1;
    logic        eof      = 1'b1;
    logic [31:0] d        = 32'hC0FFEE11;
    logic [7:0]  thresh   = 8'd0;
    logic [7:0]  q;
    logic [7:0]  q_bin;
    logic        q_valid;
    logic [7:0]  frame_ext;
    logic        frame_valid;

    stream_extremum #(.WIDTH(8), .N(4), .HI(8'd255), .LO(8'd0)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .mode(mode),
        .sof(sof), .eof(eof), .d(d), .thresh(thresh),
        .q(q), .q_bin(q_bin), .q_valid(q_valid),
        .frame_ext(frame_ext), .frame_valid(frame_valid)
    );

    always #5 clk = ~clk;

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;
    int last_ed = 0;

    // expectations indexed by the clock edge at which they become visible
    bit         rst_hist [HN];
    logic [7:0] thr_hist [HN];
    bit         exp_v    [HN];
    logic [7:0] exp_q    [HN];
    bit         exp_m    [HN];
    bit         exp_s    [HN];
    bit         exp_e    [HN];
    bit         exp_fv   [HN];
    logic [7:0] exp_fe   [HN];
    bit         tab_has  [HN];
    logic [7:0] tab_q    [HN];
    logic [7:0] tab_qb   [HN];
    bit         hand_has [HN];
    logic [7:0] hand_fe  [HN];

    bit         fin  = 1'b0;
    bit         fmd  = 1'b0;
    logic [7:0] facc = 8'd0;

    typedef struct {
        logic [31:0] d;
        bit          m;
        logic [7:0]  th;
        logic [7:0]  q;
        logic [7:0]  qb;
    } vec_t;
    vec_t tab [8];

    function automatic logic [7:0] ref_beat(input logic [31:0] dd, input bit mn);
        logic [7:0] best;
        logic [7:0] s;
        best = dd[7:0];
        for (int i = 1; i < 4; i++) begin
            s = dd[i*8 +: 8];
            if (mn ? (s < best) : (s > best)) best = s;
        end
        return best;
    endfunction

    function automatic logic [7:0] ref_pair(input logic [7:0] a, input logic [7:0] b, input bit mn);
        if (mn) return (a < b) ? a : b;
        return (a > b) ? a : b;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s edge %0d: got %0d want %0d", nm, cyc, act, exp);
    endtask

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (cyc >= 1 && cyc < HN - 1) begin
            if (rst_hist[cyc]) begin
                chk("rst_q", q, 8'd0);
                chk("rst_q_bin", q_bin, 8'd0);
                chk("rst_q_valid", 8'(q_valid), 8'd0);
                chk("rst_frame_valid", 8'(frame_valid), 8'd0);
                chk("rst_frame_ext", frame_ext, 8'd0);
                fin = 1'b0;
            end else begin
                chk("q_valid", 8'(q_valid), 8'(exp_v[cyc]));
                if (exp_v[cyc]) begin
                    chk("q", q, exp_q[cyc]);
                    chk("q_bin", q_bin, (exp_q[cyc] > thr_hist[cyc]) ? 8'd255 : 8'd0);
                end
                if (tab_has[cyc]) begin
                    chk("tab_q", q, tab_q[cyc]);
                    chk("tab_q_bin", q_bin, tab_qb[cyc]);
                end
                chk("frame_valid", 8'(frame_valid), 8'(exp_fv[cyc]));
                if (exp_fv[cyc]) chk("frame_ext", frame_ext, exp_fe[cyc]);
                if (hand_has[cyc]) begin
                    chk("hand_frame_valid", 8'(frame_valid), 8'd1);
                    chk("hand_frame_ext", frame_ext, hand_fe[cyc]);
                end
                if (exp_v[cyc]) begin
                    if (exp_s[cyc]) begin
                        facc = exp_q[cyc];
                        fmd  = exp_m[cyc];
                        fin  = 1'b1;
                    end else if (fin) begin
                        facc = ref_pair(facc, exp_q[cyc], fmd);
                    end
                    if (exp_e[cyc] && fin) begin
                        exp_fv[cyc+1] = 1'b1;
                        exp_fe[cyc+1] = facc;
                        fin = 1'b0;
                    end
                end
            end
        end
    end

    // apply one cycle of inputs; they are sampled at edge last_ed
    task automatic drive(input bit rst, input bit v, input bit md, input bit s,
                         input bit e, input logic [31:0] dd, input logic [7:0] th);
        int due;
        @(posedge clk);
        #1;
        reset = rst; in_valid = v; mode = md; sof = s; eof = e; d = dd; thresh = th;
        last_ed = cyc + 1;
        rst_hist[last_ed] = rst;
        thr_hist[last_ed] = th;
        if (rst) begin
            for (int i = 0; i <= int'(LAT); i++) exp_v[last_ed+i] = 1'b0;
        end else if (v) begin
            due = last_ed + int'(LAT);
            exp_v[due] = 1'b1;
            exp_q[due] = ref_beat(dd, md);
            exp_m[due] = md;
            exp_s[due] = s;
            exp_e[due] = e;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'($urandom));
    endtask

    task automatic expect_frame(input logic [7:0] val);
        hand_has[last_ed + int'(LAT) + 1] = 1'b1;
        hand_fe[last_ed + int'(LAT) + 1]  = val;
    endtask

    initial begin
        tab[0] = '{{8'd77, 8'd3, 8'd200, 8'd9},   1'b0, 8'd100, 8'd200, 8'd255};
        tab[1] = '{{8'd77, 8'd3, 8'd200, 8'd9},   1'b1, 8'd100, 8'd3,   8'd0};
        tab[2] = '{{8'd42, 8'd42, 8'd42, 8'd42},  1'b0, 8'd42,  8'd42,  8'd0};
        tab[3] = '{{8'd42, 8'd42, 8'd42, 8'd42},  1'b1, 8'd41,  8'd42,  8'd255};
        tab[4] = '{{8'd0, 8'd255, 8'd0, 8'd255},  1'b1, 8'd0,   8'd0,   8'd0};
        tab[5] = '{{8'd1, 8'd0, 8'd0, 8'd0},      1'b0, 8'd0,   8'd1,   8'd255};
        tab[6] = '{{8'd255, 8'd255, 8'd9, 8'd255},1'b0, 8'd254, 8'd255, 8'd255};
        tab[7] = '{{8'd4, 8'd3, 8'd2, 8'd1},      1'b1, 8'd0,   8'd1,   8'd255};

        rst_hist[1] = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h11223344, 8'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h55667788, 8'd0);

        // back-to-back vectors; thresh for a result is applied LAT beats later
        for (int i = 0; i < 8 + int'(LAT); i++) begin
            logic [7:0] th;
            th = (i >= int'(LAT)) ? tab[i-int'(LAT)].th : 8'd0;
            if (i < 8) begin
                drive(1'b0, 1'b1, tab[i].m, 1'b0, 1'b0, tab[i].d, th);
                tab_has[last_ed + int'(LAT)] = 1'b1;
                tab_q[last_ed + int'(LAT)]   = tab[i].q;
                tab_qb[last_ed + int'(LAT)]  = tab[i].qb;
            end else begin
                drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, th);
            end
        end
        idle(3);

        // three-beat max frame
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, {8'd3, 8'd2, 8'd1, 8'd10}, 8'd50);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {8'd6, 8'd5, 8'd250, 8'd4}, 8'd50);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, {8'd9, 8'd40, 8'd8, 8'd7}, 8'd50);
        expect_frame(8'd250);
        idle(4);

        // single-beat frame, then a lone eof that must not pulse
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, {8'd8, 8'd7, 8'd6, 8'd5}, 8'd0);
        expect_frame(8'd5);
        idle(1);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, {8'd99, 8'd98, 8'd97, 8'd96}, 8'd0);
        idle(4);

        // min frame with a max-mode beat inside; acc keeps min semantics
        drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, {8'd80, 8'd70, 8'd60, 8'd50}, 8'd10);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {8'd90, 8'd130, 8'd120, 8'd100}, 8'd10);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, {8'd42, 8'd42, 8'd42, 8'd42}, 8'd10);
        expect_frame(8'd42);
        idle(4);

        // reset with beats in flight; the orphan eof must not pulse
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, {8'd100, 8'd1, 8'd2, 8'd3}, 8'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {8'd200, 8'd1, 8'd2, 8'd3}, 8'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, {8'd150, 8'd1, 8'd2, 8'd3}, 8'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 8'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, {8'd7, 8'd7, 8'd7, 8'd7}, 8'd0);
        idle(5);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, {8'd3, 8'd3, 8'd3, 8'd3}, 8'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, {8'd9, 8'd9, 8'd9, 8'd9}, 8'd0);
        expect_frame(8'd9);
        idle(4);

        // random traffic, including back-to-back frames and rare resets
        for (int i = 0; i < 800; i++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 7),
                  1'($urandom), ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0),
                  $urandom, 8'($urandom));
        end
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
